// File: rtl/rgb_denormalizer_if.sv
// Pixel handshake bundle for rgb_denormalizer: normalized input side and 8-bit result side.
interface rgb_denormalizer_if;
  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  R_in;
  logic signed [IN_W-1:0]  G_in;
  logic signed [IN_W-1:0]  B_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        R_out;
  logic [OUT_W-1:0]        G_out;
  logic [OUT_W-1:0]        B_out;

  modport master (
    output in_valid, R_in, G_in, B_in, out_ready,
    input  in_ready, out_valid, R_out, G_out, B_out
  );

  modport slave (
    input  in_valid, R_in, G_in, B_in, out_ready,
    output in_ready, out_valid, R_out, G_out, B_out
  );
endinterface

// File: rtl/rgb_denormalizer.sv
// Converts normalized RGB (0..SCALE) to 8-bit channels with round-half-up, using one shared
// 8-cycle restoring divider per channel. Optional macro DENORM_SAT_FLAG_EN adds the sat output.
module rgb_denormalizer #(
  parameter int unsigned SCALE = 1000000
) (
  input  logic               Clk,
  input  logic               Reset,
  rgb_denormalizer_if.slave  bus
`ifdef DENORM_SAT_FLAG_EN
  ,
  output logic               sat
`endif
);
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 8;
  localparam logic [DW-1:0] SCALE_W = DW'(SCALE);
  localparam logic [DW-1:0] HALF_W  = DW'(SCALE / 2);
  localparam logic [DW-1:0] MUL_W   = DW'(255);

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [2:0]      bit_q, bit_d;
  logic [DW-1:0]   c_r_q, c_r_d, c_g_q, c_g_d, c_b_q, c_b_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [OW-1:0]   quo_q, quo_d;
  logic [OW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [DW-1:0]   cur_c, rem_cur, trial, rem_nxt;
  logic            q_bit;
  logic [OW-1:0]   quo_nxt;

  function automatic logic [DW-1:0] clamp_ch(input logic signed [DW-1:0] v);
    if (v < 0)                       return '0;
    else if (v > $signed(SCALE_W))   return SCALE_W;
    else                             return $unsigned(v);
  endfunction

`ifdef DENORM_SAT_FLAG_EN
  logic sat_pend_q, sat_pend_d;
  logic sat_q, sat_d;

  function automatic logic is_clamped(input logic signed [DW-1:0] v);
    return (v < 0) || (v > $signed(SCALE_W));
  endfunction

  assign sat = sat_q;
`endif

  // One restoring step: the first bit of each channel seeds the remainder with c*255 + SCALE/2.
  always_comb begin
    case (ch_q)
      2'd0:    cur_c = c_r_q;
      2'd1:    cur_c = c_g_q;
      default: cur_c = c_b_q;
    endcase
    rem_cur = (bit_q == 3'd0) ? (cur_c * MUL_W + HALF_W) : rem_q;
    trial   = SCALE_W << (3'd7 - bit_q);
    q_bit   = (rem_cur >= trial);
    rem_nxt = q_bit ? (rem_cur - trial) : rem_cur;
    quo_nxt = {quo_q[OW-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    c_r_d   = c_r_q;
    c_g_d   = c_g_q;
    c_b_d   = c_b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
`ifdef DENORM_SAT_FLAG_EN
    sat_pend_d = sat_pend_q;
    sat_d      = sat_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          c_r_d   = clamp_ch(bus.R_in);
          c_g_d   = clamp_ch(bus.G_in);
          c_b_d   = clamp_ch(bus.B_in);
          ch_d    = 2'd0;
          bit_d   = 3'd0;
          state_d = DIV;
`ifdef DENORM_SAT_FLAG_EN
          sat_pend_d = is_clamped(bus.R_in) || is_clamped(bus.G_in) || is_clamped(bus.B_in);
`endif
        end
      end
      DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          ch_d = ch_q + 2'd1;
          case (ch_q)
            2'd0: r_d = quo_nxt;
            2'd1: g_d = quo_nxt;
            default: begin
              b_d     = quo_nxt;
              ch_d    = 2'd0;
              state_d = HOLD;
`ifdef DENORM_SAT_FLAG_EN
              sat_d   = sat_pend_q;
`endif
            end
          endcase
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      bit_q       <= '0;
      c_r_q       <= '0;
      c_g_q       <= '0;
      c_b_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DENORM_SAT_FLAG_EN
      sat_pend_q  <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      c_r_q       <= c_r_d;
      c_g_q       <= c_g_d;
      c_b_q       <= c_b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef DENORM_SAT_FLAG_EN
      sat_pend_q  <= sat_pend_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.R_out     = r_q;
  assign bus.G_out     = g_q;
  assign bus.B_out     = b_q;
endmodule
